// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the 16-bit pipelined CPU: shift opcodes,
// Shifter mode encodings and EX-stage forwarding selects.
package cpu_isa_pkg;

   localparam logic [3:0] OPC_SLL = 4'h4;
   localparam logic [3:0] OPC_SRA = 4'h5;
   localparam logic [3:0] OPC_ROR = 4'h6;

   typedef enum logic [1:0] {
      SHM_SLL = 2'b00,
      SHM_SRA = 2'b01,
      SHM_ROR = 2'b10
   } shm_e;

   typedef enum logic [1:0] {
      FWD_IDEX     = 2'b00,
      FWD_EX       = 2'b01,
      FWD_WB       = 2'b10,
      FWD_IDEX_ALT = 2'b11
   } fwd_e;

   function automatic logic is_shift(input logic [3:0] opc);
      return (opc == OPC_SLL) || (opc == OPC_SRA) || (opc == OPC_ROR);
   endfunction

   function automatic shm_e opc_to_shm(input logic [3:0] opc);
      case (opc)
         OPC_SRA: return SHM_SRA;
         OPC_ROR: return SHM_ROR;
         default: return SHM_SLL;
      endcase
   endfunction

endpackage

// File: rtl/Shifter.sv
// Fixed 16-bit shifter: logical left, arithmetic right, rotate right by 0..15.
module Shifter
   import cpu_isa_pkg::*;
(
   input  logic [15:0] Shift_in,
   input  logic [3:0]  Shift_val,
   input  logic [1:0]  Mode,
   output logic [15:0] Shift_out
);

   logic [4:0] w_rot_left;

   assign w_rot_left = 5'd16 - {1'b0, Shift_val};

   always_comb begin
      Shift_out = Shift_in;
      case (Mode)
         SHM_SLL: Shift_out = Shift_in << Shift_val;
         SHM_SRA: Shift_out = $signed(Shift_in) >>> Shift_val;
         // a rotate by 0 shifts the left half out entirely, leaving Shift_in
         SHM_ROR: Shift_out = (Shift_in >> Shift_val) | (Shift_in << w_rot_left);
         default: Shift_out = Shift_in;
      endcase
   end

endmodule

// File: rtl/ex_shift_lane.sv
// Execute-stage shift lane: ID/EX register, rs forwarding mux, Shifter,
// EX/MEM result register and Z flag.
module ex_shift_lane
   import cpu_isa_pkg::*;
#(
   parameter int DATA_W     = 16,
   parameter int REG_ADDR_W = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  flush,
   input  logic                  id_valid,
   input  logic [3:0]            id_opcode,
   input  logic [DATA_W-1:0]     id_rs_val,
   input  logic [3:0]            id_imm,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic [1:0]            fwd_sel,
   input  logic [DATA_W-1:0]     wb_data,
   output logic                  idex_valid,
   output logic [REG_ADDR_W-1:0] idex_rd,
   output logic                  ex_valid,
   output logic [DATA_W-1:0]     ex_result,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_we,
   output logic                  flag_z
);

   logic                  r_idex_valid;
   logic [REG_ADDR_W-1:0] r_idex_rd;
   shm_e                  r_idex_mode;
   logic [DATA_W-1:0]     r_idex_rs;
   logic [3:0]            r_idex_imm;

   logic                  r_ex_valid;
   logic [DATA_W-1:0]     r_ex_result;
   logic [REG_ADDR_W-1:0] r_ex_rd;
   logic                  r_flag_z;

   logic [DATA_W-1:0]     w_shift_in;
   logic [DATA_W-1:0]     w_shift_out;

   // Flush only kills the slot's valid bit; it overrides a concurrent stall.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_idex_valid <= 1'b0;
         r_idex_rd    <= '0;
         r_idex_mode  <= SHM_SLL;
         r_idex_rs    <= '0;
         r_idex_imm   <= '0;
      end else if (flush) begin
         r_idex_valid <= 1'b0;
      end else if (!stall) begin
         r_idex_valid <= id_valid & is_shift(id_opcode);
         r_idex_rd    <= id_rd;
         r_idex_mode  <= opc_to_shm(id_opcode);
         r_idex_rs    <= id_rs_val;
         r_idex_imm   <= id_imm;
      end
   end

   always_comb begin
      w_shift_in = r_idex_rs;
      case (fwd_sel)
         FWD_EX:  w_shift_in = r_ex_result;
         FWD_WB:  w_shift_in = wb_data;
         default: w_shift_in = r_idex_rs;
      endcase
   end

   Shifter u_shifter (
      .Shift_in  (w_shift_in),
      .Shift_val (r_idex_imm),
      .Mode      (r_idex_mode),
      .Shift_out (w_shift_out)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_ex_valid  <= 1'b0;
         r_ex_result <= '0;
         r_ex_rd     <= '0;
         r_flag_z    <= 1'b0;
      end else if (!stall) begin
         r_ex_valid  <= r_idex_valid;
         r_ex_result <= w_shift_out;
         r_ex_rd     <= r_idex_rd;
         if (r_idex_valid)
            r_flag_z <= (w_shift_out == '0);
      end
   end

   assign idex_valid = r_idex_valid;
   assign idex_rd    = r_idex_rd;
   assign ex_valid   = r_ex_valid;
   assign ex_result  = r_ex_result;
   assign ex_rd      = r_ex_rd;
   assign ex_we      = r_ex_valid & (r_ex_rd != '0);
   assign flag_z     = r_flag_z;

endmodule
